// File: rtl/cpu_step_ctrl.sv
// Execution controller for the single-cycle core: turns run/step/breakpoint
// controls into a one-cycle cpu_en strobe in the clk_2 domain.
module cpu_step_ctrl #(
  parameter int NBITS = 8,
  parameter int DIV   = 2,
  parameter int DEB   = 4,
  parameter int NCNT  = 16
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             bp_en,
  input  logic [NBITS-1:0] bp_addr,
  input  logic [NBITS-1:0] pc,
  output logic             cpu_en,
  output logic             halted,
  output logic             at_bp,
  output logic [1:0]       state,
  output logic [NCNT-1:0]  icount
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(DEB + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t          state_reg;
  logic [1:0]      sync1_reg;
  logic [1:0]      sync2_reg;
  logic [DW-1:0]   deb_cnt_reg;
  logic            stable_reg;
  logic            press_reg;
  logic [PW-1:0]   pre_reg;
  logic            skip_reg;
  logic            cpu_en_reg;
  logic [NCNT-1:0] icount_reg;

  logic run_s;
  logic step_s;
  logic bp_hit;

  // Bit 0 carries run, bit 1 carries step.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= {step, run};
      sync2_reg <= sync1_reg;
    end
  end

  assign run_s  = sync2_reg[0];
  assign step_s = sync2_reg[1];
  assign bp_hit = bp_en && (pc == bp_addr);

  // press fires in the same edge the stable level rises, so it is a clean 1-cycle pulse.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      deb_cnt_reg <= '0;
      stable_reg  <= 1'b0;
      press_reg   <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (step_s == stable_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        stable_reg  <= step_s;
        deb_cnt_reg <= '0;
        press_reg   <= step_s;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_reg  <= S_HALT;
      pre_reg    <= '0;
      skip_reg   <= 1'b0;
      cpu_en_reg <= 1'b0;
    end else begin
      cpu_en_reg <= 1'b0;
      case (state_reg)
        S_HALT: begin
          if (run_s) begin
            state_reg <= S_RUN;
            pre_reg   <= '0;
            skip_reg  <= 1'b1;
          end else if (press_reg) begin
            state_reg  <= S_STEP;
            cpu_en_reg <= 1'b1;
          end
        end
        S_RUN: begin
          pre_reg <= (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
          if (!run_s) begin
            state_reg <= S_HALT;
          end else if (pre_reg == PRE_LAST) begin
            // skip lets a restart on the breakpoint PC execute past it once.
            if (bp_hit && !skip_reg) begin
              state_reg <= S_BREAK;
            end else begin
              cpu_en_reg <= 1'b1;
              skip_reg   <= 1'b0;
            end
          end
        end
        S_STEP: begin
          state_reg <= S_HALT;
        end
        S_BREAK: begin
          if (!run_s) begin
            state_reg <= S_HALT;
          end else if (press_reg) begin
            state_reg  <= S_STEP;
            cpu_en_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      icount_reg <= '0;
    end else if (cpu_en_reg) begin
      icount_reg <= icount_reg + 1'b1;
    end
  end

  assign cpu_en = cpu_en_reg;
  assign state  = state_reg;
  assign icount = icount_reg;
  assign halted = (state_reg == S_HALT) || (state_reg == S_BREAK);
  assign at_bp  = (state_reg == S_BREAK);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl; a second narrow-counter instance shares the
// inputs so icount wrap can be reached in a short run.
module tb_cpu_step_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'h00;
  logic [7:0] pc = 8'h00;

  logic        cpu_en, halted, at_bp;
  logic [1:0]  state;
  logic [15:0] icount;
  logic        cpu_en_n, halted_n, at_bp_n;
  logic [1:0]  state_n;
  logic [3:0]  icount_n;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_step_ctrl #(.NBITS(8), .DIV(2), .DEB(4), .NCNT(16)) dut (
    .clk_2(clk_2), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en), .halted(halted),
    .at_bp(at_bp), .state(state), .icount(icount)
  );

  cpu_step_ctrl #(.NBITS(8), .DIV(2), .DEB(4), .NCNT(4)) dut_n (
    .clk_2(clk_2), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en_n), .halted(halted_n),
    .at_bp(at_bp_n), .state(state_n), .icount(icount_n)
  );

  always #5 clk_2 = ~clk_2;

  // Core PC model: advances by one instruction on every enabled edge.
  always @(posedge clk_2) begin
    if (reset) pc <= 8'h00;
    else if (cpu_en) pc <= pc + 8'd4;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = 8'h00;
    tick();
    tick();
    check("rst_state", state, 2'd0);
    check("rst_cpu_en", cpu_en, 1'b0);
    check("rst_icount", icount, 16'd0);
    check("rst_halted", halted, 1'b1);
    check("rst_at_bp", at_bp, 1'b0);
    check("rst_narrow", {cpu_en_n, halted_n, at_bp_n, state_n, icount_n}, {3'b010, 2'd0, 4'd0});
    reset = 1'b0;
  endtask

  task automatic run_to_break();
    int np;
    logic [7:0] pcs [0:3];
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h0C; run = 1'b1;
    np = 0;
    for (int k = 0; k < 4; k++) pcs[k] = 8'hFF;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (cpu_en) begin
        if (np < 4) pcs[np] = pc;
        np++;
      end
    end
    check("bp_pulses", np, 3);
    check("bp_pc0", pcs[0], 8'h00);
    check("bp_pc1", pcs[1], 8'h04);
    check("bp_pc2", pcs[2], 8'h08);
    check("bp_state", state, 2'd3);
    check("bp_flags", {halted, at_bp}, 2'b11);
    check("bp_icount", icount, 16'd3);
    check("bp_pc", pc, 8'h0C);
  endtask

  initial begin
    int np, first, adj, post, nbrk, found;
    logic prev;
    logic [1:0] st_at;
    logic [7:0] pc0, pc1;

    // Debounced single step: press 6 cycles after sampling, strobe one later.
    do_reset();
    step = 1'b1;
    np = 0; first = 0; st_at = 2'd0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (cpu_en) begin
        np++;
        if (first == 0) begin first = n; st_at = state; end
      end
      if (n == 10) step = 1'b0;
    end
    check("step_pulses", np, 1);
    check("step_latency", first, 8);
    check("step_state_at_pulse", st_at, 2'd2);
    check("step_icount", icount, 16'd1);
    check("step_final_state", state, 2'd0);

    // Short glitches never reach the stable level.
    do_reset();
    np = 0;
    for (int r = 0; r < 5; r++) begin
      step = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); np += int'(cpu_en); end
      step = 1'b0;
      for (int k = 0; k < 8; k++) begin tick(); np += int'(cpu_en); end
    end
    check("glitch_pulses", np, 0);
    check("glitch_icount", icount, 16'd0);
    check("glitch_state", state, 2'd0);

    // Free run at DIV=2, then release.
    do_reset();
    run = 1'b1;
    np = 0; first = 0; adj = 0; prev = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (cpu_en && prev) adj++;
      if (cpu_en && first == 0) first = n;
      prev = cpu_en;
      np += int'(cpu_en);
    end
    run = 1'b0;
    post = 0; st_at = 2'd1;
    for (int n = 41; n <= 50; n++) begin
      tick();
      if (cpu_en && prev) adj++;
      prev = cpu_en;
      post += int'(cpu_en);
      if (n == 43) st_at = state;
    end
    check("run_first_pulse", first, 5);
    check("run_pulses", np, 18);
    check("run_adjacent", adj, 0);
    check("run_tail_pulses", post, 1);
    check("run_halt_by_3", st_at, 2'd0);
    check("run_icount", icount, 16'd19);

    // Restart on the breakpoint PC executes past it.
    run_to_break();
    run = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("skip_halt_state", state, 2'd0);
    run = 1'b1;
    np = 0; nbrk = 0; pc0 = 8'hFF; pc1 = 8'hFF;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (state == 2'd3) nbrk++;
      if (cpu_en) begin
        if (np == 0) pc0 = pc;
        if (np == 1) pc1 = pc;
        np++;
      end
    end
    check("skip_first_pc", pc0, 8'h0C);
    check("skip_second_pc", pc1, 8'h10);
    check("skip_no_break", nbrk, 0);
    check("skip_pulses", np, 8);

    // Step out of BREAK; run drops so the core stays halted afterwards.
    run_to_break();
    step = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    run = 1'b0;
    tick();
    check("bpstep_press_cycle", state, 2'd3);
    tick();
    check("bpstep_state", state, 2'd2);
    check("bpstep_cpu_en", cpu_en, 1'b1);
    check("bpstep_pc_before", pc, 8'h0C);
    tick();
    check("bpstep_halt", state, 2'd0);
    check("bpstep_pc_after", pc, 8'h10);
    check("bpstep_icount", icount, 16'd4);
    check("bpstep_at_bp", at_bp, 1'b0);
    step = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("bpstep_settled", {state, icount}, {2'd0, 16'd4});

    // Reset with the narrow counter at all-ones mid-RUN, then wrap without reset.
    do_reset();
    run = 1'b1;
    found = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (icount_n == 4'hF) begin found = 1; break; end
    end
    check("wrap_reach_max", found, 1);
    check("wrap_max_icount", {icount_n, icount}, {4'hF, 16'd15});
    check("wrap_in_run", state, 2'd1);
    reset = 1'b1;
    tick();
    check("midrun_rst_state", state, 2'd0);
    check("midrun_rst_cpu_en", cpu_en, 1'b0);
    check("midrun_rst_icount", {icount_n, icount}, {4'h0, 16'd0});
    reset = 1'b0;
    tick();
    check("midrun_rst_no_pulse", cpu_en, 1'b0);
    found = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (icount_n == 4'hF) begin found = 1; break; end
    end
    check("wrap_reach_max2", found, 1);
    found = 0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (cpu_en) begin found = 1; break; end
    end
    check("wrap_pulse_seen", found, 1);
    tick();
    check("wrap_narrow_zero", icount_n, 4'h0);
    check("wrap_wide_16", icount, 16'd16);
    check("wrap_narrow_state", state_n, state);
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
